// File: rtl/dmem_bus_port.sv
// Data-memory port on the shared register bus.
// Fixed-latency reads onto an OR-safe bus, one-cycle write commits.
module dmem_bus_port #(
  parameter int N      = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N-1:0]      datain,
  output logic [N-1:0]      dataout,
  output logic              bus_drive,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR
  } state_e;

  localparam logic [2:0] CNT_INIT =
    (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]      data_q, data_d;
  logic              drive_q, drive_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [N-1:0]      mem [DEPTH];
  logic [N-1:0]      rdata_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drive_q <= drive_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    drive_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_req && wr_req) begin
          err_d = 1'b1;
        end else if (rd_req) begin
          addr_d = addr;
          if (RD_LAT == 1) begin
            state_d = RD_DRIVE;
            drive_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else if (wr_req) begin
          addr_d  = addr;
          data_d  = datain;
          state_d = WR;
          done_d  = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RD_DRIVE;
          drive_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_DRIVE: state_d = IDLE;
      WR:       state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Single-cycle reads sample the live address; longer ones the latch.
  assign rd_addr = (state_q == IDLE) ? addr : addr_q;
  assign wr_en   = (state_q == WR);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= mem[rd_addr];
  end

  assign dataout   = drive_q ? rdata_q : '0;
  assign bus_drive = drive_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_bus_port.sv
// Bench for dmem_bus_port: three latencies on shared stimulus,
// checked every cycle against a transaction-level model.
module tb_dmem_bus_port;

  localparam int NI = 3;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 8);
  endfunction

  function automatic logic [15:0] initv(input logic [7:0] a);
    return {a, ~a} ^ 16'h3C5A;
  endfunction

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic        wr_req;
  logic [7:0]  addr;
  logic [15:0] datain;

  logic [15:0] dout [NI];
  logic        drv  [NI];
  logic        bsy  [NI];
  logic        dn   [NI];
  logic        er   [NI];

  int total;
  int bad;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_bus_port #(
      .N(16), .ADDR_W(8), .DEPTH(256),
      .RD_LAT((g == 0) ? 1 : ((g == 1) ? 2 : 8))
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .rd_req(rd_req),
      .wr_req(wr_req),
      .addr(addr),
      .datain(datain),
      .dataout(dout[g]),
      .bus_drive(drv[g]),
      .busy(bsy[g]),
      .done(dn[g]),
      .err(er[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // Model: each op occupies a number of cycles; last one pulses done.
  logic [15:0] mm    [NI][256];
  int          rem   [NI];
  bit          opw   [NI];
  logic [7:0]  pa    [NI];
  logic [15:0] pd    [NI];
  logic [15:0] rdat  [NI];
  logic [15:0] e_dout[NI];
  bit          e_drv [NI];
  bit          e_bsy [NI];
  bit          e_dn  [NI];
  bit          e_er  [NI];

  initial begin
    bit idl;
    for (int i = 0; i < NI; i++) begin
      rem[i] = 0; opw[i] = 0; e_dout[i] = '0;
      e_drv[i] = 0; e_bsy[i] = 0; e_dn[i] = 0; e_er[i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          rem[i] = 0; e_dout[i] = '0;
          e_drv[i] = 0; e_bsy[i] = 0; e_dn[i] = 0; e_er[i] = 0;
        end else begin
          idl = (rem[i] == 0);
          e_er[i] = 0;
          if (!idl) begin
            rem[i]--;
            if (rem[i] == 0 && opw[i]) mm[i][pa[i]] = pd[i];
          end else if (rd_req && wr_req) begin
            e_er[i] = 1;
          end else if (rd_req) begin
            rem[i] = lat_of(i); opw[i] = 0; rdat[i] = mm[i][addr];
          end else if (wr_req) begin
            rem[i] = 1; opw[i] = 1; pa[i] = addr; pd[i] = datain;
          end
          e_bsy[i] = (rem[i] > 0);
          e_dn[i]  = (rem[i] == 1);
          e_drv[i] = (rem[i] == 1) && !opw[i];
          e_dout[i] = e_drv[i] ? rdat[i] : 16'h0;
        end
      end
    end
  end

  initial begin
    @(negedge rst_n);
    forever begin
      @(posedge clk);
      #3;
      for (int i = 0; i < NI; i++) begin
        total++;
        if (dout[i] !== e_dout[i] || drv[i] !== e_drv[i] ||
            bsy[i] !== e_bsy[i] || dn[i] !== e_dn[i] ||
            er[i] !== e_er[i]) begin
          bad++;
          $display("FAIL cycle L=%0d t=%0t: got d=%h v=%b b=%b dn=%b e=%b want d=%h v=%b b=%b dn=%b e=%b",
                   lat_of(i), $time, dout[i], drv[i], bsy[i], dn[i], er[i],
                   e_dout[i], e_drv[i], e_bsy[i], e_dn[i], e_er[i]);
        end
      end
    end
  end

  function automatic void chk(input string nm, input logic [31:0] got,
                              input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b0; addr = a; datain = d;
    @(negedge clk);
    wr_req = 1'b0; datain = 16'hFFFF;
    idle(2);
  endtask

  // Instances selected by alt_m expect alt instead of ev.
  task automatic do_read(input logic [7:0] a, input logic [15:0] ev,
                         input logic [15:0] alt, input bit [NI-1:0] alt_m,
                         input string nm);
    int first [NI];
    int cnt [NI];
    logic [15:0] seen [NI];
    for (int i = 0; i < NI; i++) begin
      first[i] = -1; cnt[i] = 0; seen[i] = '0;
    end
    @(negedge clk);
    rd_req = 1'b1; wr_req = 1'b0; addr = a;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      #3;
      for (int i = 0; i < NI; i++) begin
        if (drv[i] === 1'b1) begin
          cnt[i]++;
          if (first[i] < 0) first[i] = n;
          seen[i] = dout[i];
        end
      end
      @(negedge clk);
      rd_req = 1'b0;
      @(posedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s L=%0d latency", nm, lat_of(i)), first[i], lat_of(i));
      chk($sformatf("%s L=%0d drive_cycles", nm, lat_of(i)), cnt[i], 1);
      chk($sformatf("%s L=%0d data", nm, lat_of(i)), {16'h0, seen[i]},
          {16'h0, alt_m[i] ? alt : ev});
    end
  endtask

  initial begin
    int ecnt [NI];
    int dcnt [NI];
    int bcnt [NI];
    total = 0; bad = 0;
    rst_n = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; datain = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset L=%0d out", lat_of(i)),
          {16'h0, dout[i]}, 32'h0);
      chk($sformatf("reset L=%0d flags", lat_of(i)),
          {28'h0, drv[i], bsy[i], dn[i], er[i]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    do_write(8'h05, 16'h0ABC);
    do_read(8'h05, 16'h0ABC, 16'h0, '0, "raw05");

    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      wr_req = 1'b1; addr = 8'(a); datain = initv(8'(a));
      @(negedge clk);
      wr_req = 1'b0;
    end
    idle(2);

    do_write(8'hFF, 16'h1234);
    do_read(8'hFF, 16'h1234, 16'h0, '0, "bus_change");

    do_write(8'h10, 16'h0001);
    for (int i = 0; i < NI; i++) begin
      ecnt[i] = 0; dcnt[i] = 0; bcnt[i] = 0;
    end
    @(negedge clk);
    rd_req = 1'b1; wr_req = 1'b1; addr = 8'h10; datain = 16'h5555;
    @(posedge clk);
    for (int n = 0; n < 6; n++) begin
      #3;
      for (int i = 0; i < NI; i++) begin
        if (er[i] === 1'b1) ecnt[i]++;
        if (dn[i] === 1'b1) dcnt[i]++;
        if (bsy[i] === 1'b1) bcnt[i]++;
      end
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      @(posedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("conflict L=%0d err", lat_of(i)), ecnt[i], 1);
      chk($sformatf("conflict L=%0d done", lat_of(i)), dcnt[i], 0);
      chk($sformatf("conflict L=%0d busy", lat_of(i)), bcnt[i], 0);
    end
    do_read(8'h10, 16'h0001, 16'h0, '0, "after_conflict");

    @(negedge clk);
    rd_req = 1'b1; addr = 8'h20;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b1; datain = 16'h7777;
    @(negedge clk);
    wr_req = 1'b0;
    idle(10);
    do_read(8'h20, initv(8'h20), 16'h0, '0, "busy_ignore1");

    @(negedge clk);
    rd_req = 1'b1; addr = 8'h20;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b1; datain = 16'h7777;
    repeat (8) @(negedge clk);
    wr_req = 1'b0;
    idle(4);
    do_read(8'h20, initv(8'h20), 16'h7777, 3'b011, "busy_ignore8");

    do_write(8'h30, 16'h0042);
    @(negedge clk);
    wr_req = 1'b1; addr = 8'h30; datain = 16'h0099;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("in_wr L=%0d busy", lat_of(i)), bsy[i], 1);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("midrst L=%0d out", lat_of(i)),
          {16'h0, dout[i]}, 32'h0);
      chk($sformatf("midrst L=%0d flags", lat_of(i)),
          {28'h0, drv[i], bsy[i], dn[i], er[i]}, 32'h0);
    end
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    do_read(8'h30, 16'h0042, 16'h0, '0, "write_dropped");

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      rd_req = ($urandom_range(0, 3) == 0);
      wr_req = ($urandom_range(0, 3) == 0);
      addr   = 8'($urandom);
      datain = 16'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bus_port.md
Name: dmem_bus_port

Overview:
- Data-memory port on the shared datapath bus; the other end of the register bus protocol.
- Registers such as the accumulator load from the bus; this block sources read data onto the bus and sinks write data from it.
- The control unit issues single-word read or write requests, with the address taken from the address register.
- The block holds a synchronous RAM and sequences fixed-latency reads and one-cycle write commits with a done pulse.

Parameters:
- N, 16, bus/data word width.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words; must equal 2**ADDR_W.
- RD_LAT, 2, read latency in cycles from request to bus-valid; legal range 1..8.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_req  in  1  read request, sampled only in IDLE.
- wr_req  in  1  write request, sampled only in IDLE.
- addr  in  ADDR_W  word address from the address register.
- datain  in  N  write data from the bus.
- dataout  out  N  read data to the bus; all-zero whenever bus_drive=0 (OR-bus safe).
- bus_drive  out  1  high exactly during the read-valid cycle.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse marking read-valid or write-commit.
- err  out  1  one-cycle pulse: rd_req and wr_req high together in IDLE.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; dataout=0, bus_drive=0, busy=0, done=0, err=0; latency counter=0; address/data latches=0.
- RAM contents are not reset (undefined until written).
- States: IDLE, RD_WAIT, RD_DRIVE, WR.
- IDLE, edge k, rd_req=1, wr_req=0: latch addr.
  - If RD_LAT=1, go to RD_DRIVE; otherwise go to RD_WAIT with counter=RD_LAT-2.
- RD_WAIT: decrement counter each edge; go to RD_DRIVE on the edge where counter=0.
  - The RAM read is issued from the latched address; the pipeline is internal, and total latency must equal RD_LAT.
- RD_DRIVE (one cycle): dataout=mem[latched addr], bus_drive=1, done=1; next edge returns to IDLE.
  - Consumers sample at edge k+RD_LAT.
- IDLE, edge k, wr_req=1, rd_req=0: latch addr and datain at edge k; go to WR.
- WR (one cycle): done=1; mem[latched addr] <= latched data at edge k+1; go to IDLE.
  - Bus changes after edge k do not affect the written value.
- IDLE, rd_req=1 and wr_req=1: no operation, no latching; err=1 for the following cycle; stay in IDLE.
- Requests while busy=1 are ignored, not queued. The earliest next request is accepted at the first edge after return to IDLE (back-to-back ops: request every other cycle for WR, every RD_LAT+1 cycles for reads).
- Read-after-write to the same address returns the new data; the write commits before any subsequent read can be accepted.
- Address is used as-is; no range check (DEPTH=2**ADDR_W).
- Reset mid-operation: immediate return to IDLE, all outputs 0.
  - A write in WR not yet committed at the reset edge is dropped; RAM otherwise unchanged.
  - An in-flight read is abandoned with no done.
- done, bus_drive, err are registered outputs (no combinational path from inputs).

Test Plan:
- Reset, then write addr=0x05 datain=0x0ABC at edge k; idle 1 cycle; read addr=0x05 at edge m -> bus_drive=1, done=1, dataout=0x0ABC sampled at edge m+2 (RD_LAT=2); dataout=0 in every other cycle.
- Write 0x1234 to 0xFF, datain changes to 0xFFFF at edge k+1 -> later read of 0xFF returns 0x1234; done pulses exactly once per op, busy high only in WR / RD_WAIT / RD_DRIVE.
- rd_req and wr_req both high in IDLE at addr=0x10 holding 0x0001 -> err=1 for one cycle, no done, busy stays 0; subsequent read of 0x10 returns 0x0001.
- Issue rd_req at 0x20, then hold wr_req=1 with 0x7777 at 0x20 during RD_WAIT/RD_DRIVE and drop it at return to IDLE -> write ignored; reading 0x20 again returns the original value.
- Write 0x0042 to 0x30; write 0x0099 to 0x30 and assert rst_n=0 mid-cycle while in WR -> outputs 0 immediately, state IDLE; read of 0x30 returns 0x0042.
- Rerun the first scenario with RD_LAT=1 and RD_LAT=8 -> valid cycle at edge m+1 and edge m+8 respectively, single-cycle bus_drive.
